// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO storage with pointers, occupancy count and full/empty
//
// Ports:
//   clk      system clock, all state changes on posedge
//   rst      synchronous active-high reset; clears pointers and count, not storage
//   push     write wr_data at the tail (ignored when full)
//   wr_data  word to enqueue
//   pop      advance the head (ignored when empty)
//   rd_data  word at the head; only meaningful while ~empty
//   count    occupancy, 0..DEPTH
//   full     count == DEPTH
//   empty    count == 0
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_r;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left out of reset; empty slots are never
  // exposed because the wrapper zeroes the head word while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/in_port.sv
// rtl/in_port.sv - CPU input port: producer handshake into a FIFO, CPU pops via read strobe
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   clk_en         CPU step enable; gates only the CPU-side pop
//   i_ext_valid    producer offers i_ext_data
//   i_ext_data     producer word
//   o_ext_ready    port accepts a word this cycle (~full, low during rst)
//   i_read_enable  CPU reads/pops the port
//   o_data         head word, zero while empty
//   o_empty        FIFO holds no words
//   o_full         FIFO holds DEPTH words
//   o_count        occupancy 0..DEPTH
//   o_underflow    sticky: a pop was attempted while empty
module in_port #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             i_ext_valid,
  input  logic [WIDTH-1:0] i_ext_data,
  output logic             o_ext_ready,
  input  logic             i_read_enable,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count,
  output logic             o_underflow
);

  logic             push;
  logic             pop_req;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic             empty;
  logic             full;
  logic             underflow_r;

  // Ready comes from the registered count only: a pop in the same cycle
  // does not free a slot for a push (no pass-through when full).
  assign o_ext_ready = ~full & ~rst;
  assign push        = i_ext_valid & o_ext_ready;

  // The producer side is free-running; only the CPU pop honours clk_en.
  assign pop_req = clk_en & i_read_enable;
  assign pop     = pop_req & ~empty;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (i_ext_data),
    .pop     (pop),
    .rd_data (head),
    .count   (o_count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_r <= 1'b0;
    end else if (pop_req & empty) begin
      underflow_r <= 1'b1;
    end
  end

  assign o_data      = empty ? '0 : head;
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_underflow = underflow_r;

endmodule

// File: tb/tb_in_port.sv
// tb/tb_in_port.sv - self-checking bench for in_port
module tb_in_port;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             clk_en;
  logic             i_ext_valid;
  logic [WIDTH-1:0] i_ext_data;
  logic             o_ext_ready;
  logic             i_read_enable;
  logic [WIDTH-1:0] o_data;
  logic             o_empty;
  logic             o_full;
  logic [CNT_W-1:0] o_count;
  logic             o_underflow;

  in_port #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_ext_valid   (i_ext_valid),
    .i_ext_data    (i_ext_data),
    .o_ext_ready   (o_ext_ready),
    .i_read_enable (i_read_enable),
    .o_data        (o_data),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_count       (o_count),
    .o_underflow   (o_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: an ordered list of held words plus the sticky flag.
  logic [WIDTH-1:0] mq[$];
  bit               muf;

  typedef struct {
    logic             rst;
    logic             v;
    logic [WIDTH-1:0] d;
    logic             ce;
    logic             re;
    logic             rdy;
    logic [WIDTH-1:0] dat;
    int               cnt;
    logic             emp;
    logic             ful;
    logic             uf;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic r, logic v, logic [WIDTH-1:0] d, logic ce, logic re,
                              logic rdy, logic [WIDTH-1:0] dat, int cnt,
                              logic emp, logic ful, logic uf);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.ce = ce; x.re = re;
    x.rdy = rdy; x.dat = dat; x.cnt = cnt; x.emp = emp; x.ful = ful; x.uf = uf;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [WIDTH-1:0] d,
                            input bit ce, input bit re);
    bit can_push;
    logic [WIDTH-1:0] dummy;
    can_push = (mq.size() < DEPTH);
    if (r) begin
      mq.delete();
      muf = 1'b0;
    end else begin
      if (ce && re) begin
        if (mq.size() == 0) muf = 1'b1;
        else dummy = mq.pop_front();
      end
      if (v && can_push) mq.push_back(d);
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [WIDTH-1:0] d,
                       input bit ce, input bit re);
    rst = r; i_ext_valid = v; i_ext_data = d; clk_en = ce; i_read_enable = re;
  endtask

  task automatic check_model(input string tag);
    logic [WIDTH-1:0] ed;
    ed = (mq.size() > 0) ? mq[0] : '0;
    chk({tag, ".ready"}, 32'(o_ext_ready), 32'(!rst && (mq.size() < DEPTH)));
    chk({tag, ".data"},  32'(o_data),      32'(ed));
    chk({tag, ".count"}, 32'(o_count),     32'(mq.size()));
    chk({tag, ".empty"}, 32'(o_empty),     32'(mq.size() == 0));
    chk({tag, ".full"},  32'(o_full),      32'(mq.size() == DEPTH));
    chk({tag, ".uflow"}, 32'(o_underflow), 32'(muf));
  endtask

  // One clock: drive, settle, compare against the model, take the edge.
  task automatic cycle(input string tag, input bit r, input bit v,
                       input logic [WIDTH-1:0] d, input bit ce, input bit re);
    drive(r, v, d, ce, re);
    #1;
    check_model(tag);
    @(posedge clk);
    model_edge(r, v, d, ce, re);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    model_edge(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    muf = 1'b0;

    // Fill, hold-off at full, drain in order, underflow.
    //           rst v  d        ce re  rdy dat     cnt emp ful uf
    tbl[0]  = mk(0, 0, 16'h0000, 0, 0,  1, 16'h0000, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 16'h1111, 0, 0,  1, 16'h0000, 0, 1, 0, 0);
    tbl[2]  = mk(0, 1, 16'h2222, 0, 0,  1, 16'h1111, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 16'h3333, 0, 0,  1, 16'h1111, 2, 0, 0, 0);
    tbl[4]  = mk(0, 1, 16'h4444, 0, 0,  1, 16'h1111, 3, 0, 0, 0);
    tbl[5]  = mk(0, 1, 16'h5555, 0, 0,  0, 16'h1111, 4, 0, 1, 0);
    tbl[6]  = mk(0, 1, 16'h5555, 1, 1,  0, 16'h1111, 4, 0, 1, 0);
    tbl[7]  = mk(0, 1, 16'h5555, 1, 1,  1, 16'h2222, 3, 0, 0, 0);
    tbl[8]  = mk(0, 0, 16'h0000, 1, 1,  1, 16'h3333, 3, 0, 0, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 1,  1, 16'h4444, 2, 0, 0, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 1,  1, 16'h5555, 1, 0, 0, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 0,  1, 16'h0000, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 16'h0000, 1, 1,  1, 16'h0000, 0, 1, 0, 0);
    tbl[13] = mk(0, 1, 16'hAAAA, 0, 0,  1, 16'h0000, 0, 1, 0, 1);
    tbl[14] = mk(0, 0, 16'h0000, 0, 0,  1, 16'hAAAA, 1, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].ce, tbl[i].re);
      #1;
      chk($sformatf("tbl%0d.ready", i), 32'(o_ext_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d.data", i),  32'(o_data),      32'(tbl[i].dat));
      chk($sformatf("tbl%0d.count", i), 32'(o_count),     32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.empty", i), 32'(o_empty),     32'(tbl[i].emp));
      chk($sformatf("tbl%0d.full", i),  32'(o_full),      32'(tbl[i].ful));
      chk($sformatf("tbl%0d.uflow", i), 32'(o_underflow), 32'(tbl[i].uf));
      @(posedge clk);
      model_edge(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].ce, tbl[i].re);
      #1;
    end

    // Underflow flag survives further pushes/pops until reset.
    cycle("uf_pop", 0, 1, 16'hBBBB, 1, 1);
    chk("uf_held", 32'(o_underflow), 32'd1);
    do_reset();
    chk("uf_cleared", 32'(o_underflow), 32'd0);

    // Read strobe while the CPU is not stepped must not pop.
    cycle("ce_fill", 0, 1, 16'hC001, 0, 0);
    cycle("ce_fill", 0, 1, 16'hC002, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("ce_hold", 0, 0, '0, 0, 1);
    end
    chk("ce_hold.count", 32'(o_count), 32'd2);
    chk("ce_hold.data", 32'(o_data), 32'hC001);
    chk("ce_hold.uflow", 32'(o_underflow), 32'd0);
    cycle("ce_step", 0, 0, '0, 1, 1);
    chk("ce_step.count", 32'(o_count), 32'd1);
    chk("ce_step.data", 32'(o_data), 32'hC002);

    // Simultaneous push and pop at count 2.
    cycle("sim_fill", 0, 1, 16'hC003, 0, 0);
    cycle("sim_pp", 0, 1, 16'hAAAA, 1, 1);
    chk("sim.count", 32'(o_count), 32'd2);
    chk("sim.head", 32'(o_data), 32'hC003);
    cycle("sim_pop1", 0, 0, '0, 1, 1);
    chk("sim.tail", 32'(o_data), 32'hAAAA);
    cycle("sim_pop2", 0, 0, '0, 1, 1);

    // Reset mid-transfer with a push in flight.
    cycle("rst_fill", 0, 1, 16'hD001, 0, 0);
    cycle("rst_fill", 0, 1, 16'hD002, 0, 0);
    cycle("rst_fill", 0, 1, 16'hD003, 0, 0);
    drive(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    #1;
    chk("rst.ready_low", 32'(o_ext_ready), 32'd0);
    @(posedge clk);
    model_edge(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    #1;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("rst.count", 32'(o_count), 32'd0);
    chk("rst.empty", 32'(o_empty), 32'd1);
    chk("rst.data", 32'(o_data), 32'd0);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cycle("wrap_push", 0, 1, 16'(16'hE000 + i), 0, 0);
      cycle("wrap_pop", 0, 0, '0, 1, 1);
    end

    // Randomised traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      cycle("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
            16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
